// File: rtl/connect4_pkg.sv
// Shared types and constants for the connect-four move stage: board size defaults,
// turn FSM encoding, player encoding and bit positions of the {left,right,put} pulses.
package connect4_pkg;

    localparam int COLS_DEF = 7;
    localparam int ROWS_DEF = 6;

    localparam int LRP_LEFT  = 2;
    localparam int LRP_RIGHT = 1;
    localparam int LRP_PUT   = 0;

    typedef enum logic [2:0] {
        SELF_TURN = 3'd0,
        DROP      = 3'd1,
        CHECK     = 3'd2,
        OPP_TURN  = 3'd3,
        END       = 3'd4
    } turn_state_t;

    typedef logic player_t;

    localparam player_t PLAYER_SELF = 1'b0;
    localparam player_t PLAYER_OPP  = 1'b1;

endpackage

// File: rtl/tx_pulse_stretch.sv
// Stretches a one-hot {left,right,put} event into a tx line held high for TX_HOLD cycles.
// A new event while holding restarts the hold and replaces the active line.
module tx_pulse_stretch #(
    parameter int TX_HOLD = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       clear,
    input  logic [2:0] ev_in,
    output logic [2:0] tx_lines
);

    localparam int            CW      = (TX_HOLD > 1) ? $clog2(TX_HOLD) : 1;
    localparam logic [CW-1:0] HOLD_M1 = CW'(TX_HOLD - 1);

    logic [CW-1:0] hold_cnt;

    // hold_cnt counts the remaining high cycles after the current one.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            tx_lines <= '0;
            hold_cnt <= '0;
        end else if (clear) begin
            tx_lines <= '0;
            hold_cnt <= '0;
        end else if (ev_in != 3'b000) begin
            tx_lines <= ev_in;
            hold_cnt <= HOLD_M1;
        end else if (hold_cnt != '0) begin
            hold_cnt <= hold_cnt - CW'(1);
        end else begin
            tx_lines <= '0;
        end
    end

endmodule

// File: rtl/turn_controller.sv
// Connect-four move stage: shared cursor, column heights, turn FSM, board writes and
// mirroring of own moves to the opponent board. Define CURSOR_WRAP_EN for a wrapping cursor.
module turn_controller
    import connect4_pkg::*;
#(
    parameter int COLS       = COLS_DEF,
    parameter int ROWS       = ROWS_DEF,
    parameter int START_SELF = 1,
    parameter int TX_HOLD    = 8
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [2:0]              lrp_self,
    input  logic [2:0]              lrp_opponent,
    input  logic                    new_game,
    input  logic                    win_detect,
    output logic [$clog2(COLS)-1:0] cursor_col,
    output logic                    wr_en,
    output logic [$clog2(ROWS)-1:0] wr_row,
    output logic [$clog2(COLS)-1:0] wr_col,
    output logic                    wr_player,
    output logic                    self_turn,
    output logic                    game_end,
    output logic                    col_full_err,
    output logic                    tx_left,
    output logic                    tx_right,
    output logic                    tx_put,
    output turn_state_t             state_dbg
);

    localparam int CW = $clog2(COLS);
    localparam int RW = $clog2(ROWS);
    localparam int HW = $clog2(ROWS + 1);
    localparam int MW = $clog2(ROWS * COLS + 1);

    localparam logic [CW-1:0] CUR_MAX   = CW'(COLS - 1);
    localparam logic [CW-1:0] CUR_MID   = CW'(COLS / 2);
    localparam logic [HW-1:0] ROWS_H    = HW'(ROWS);
    localparam logic [MW-1:0] MOVES_MAX = MW'(ROWS * COLS);
    localparam turn_state_t   START_ST  = (START_SELF != 0) ? SELF_TURN : OPP_TURN;

    turn_state_t   state, next_state;
    logic [HW-1:0] heights [COLS];
    logic [MW-1:0] moves;
    player_t       player_q;

    logic [2:0]    src;
    logic          mv_left, mv_right, mv_put;
    logic [HW-1:0] col_h;
    logic          put_ok, put_full;
    logic [CW-1:0] cursor_nxt;
    logic [2:0]    tx_ev;
    logic [2:0]    tx_lines;

    always_comb begin
        src = 3'b000;
        if (state == SELF_TURN)
            src = lrp_self;
        else if (state == OPP_TURN)
            src = lrp_opponent;

        // Multi-hot input resolves as left > right > put.
        mv_left  = src[LRP_LEFT];
        mv_right = src[LRP_RIGHT] & ~src[LRP_LEFT];
        mv_put   = src[LRP_PUT] & ~src[LRP_LEFT] & ~src[LRP_RIGHT];

        col_h    = heights[cursor_col];
        put_ok   = mv_put && (col_h < ROWS_H);
        put_full = mv_put && !(col_h < ROWS_H);

        cursor_nxt = cursor_col;
        if (mv_left) begin
            if (cursor_col != '0)
                cursor_nxt = cursor_col - CW'(1);
`ifdef CURSOR_WRAP_EN
            else
                cursor_nxt = CUR_MAX;
`endif
        end else if (mv_right) begin
            if (cursor_col != CUR_MAX)
                cursor_nxt = cursor_col + CW'(1);
`ifdef CURSOR_WRAP_EN
            else
                cursor_nxt = '0;
`endif
        end

        // Only own moves are mirrored; saturated moves still go out to keep boards aligned.
        tx_ev = 3'b000;
        if (state == SELF_TURN) begin
            tx_ev[LRP_LEFT]  = mv_left;
            tx_ev[LRP_RIGHT] = mv_right;
            tx_ev[LRP_PUT]   = put_ok;
        end

        next_state = state;
        case (state)
            SELF_TURN, OPP_TURN: if (put_ok) next_state = DROP;
            DROP:                next_state = CHECK;
            CHECK: begin
                if (win_detect || moves == MOVES_MAX)
                    next_state = END;
                else if (player_q == PLAYER_SELF)
                    next_state = OPP_TURN;
                else
                    next_state = SELF_TURN;
            end
            END:                 next_state = END;
            default:             next_state = START_ST;
        endcase
        if (new_game)
            next_state = START_ST;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= START_ST;
            self_turn <= (START_ST == SELF_TURN);
            game_end  <= 1'b0;
        end else begin
            state     <= next_state;
            self_turn <= (next_state == SELF_TURN);
            game_end  <= (next_state == END);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < COLS; i++)
                heights[i] <= '0;
            moves        <= '0;
            cursor_col   <= CUR_MID;
            player_q     <= PLAYER_SELF;
            wr_en        <= 1'b0;
            wr_row       <= '0;
            wr_col       <= '0;
            wr_player    <= 1'b0;
            col_full_err <= 1'b0;
        end else if (new_game) begin
            for (int i = 0; i < COLS; i++)
                heights[i] <= '0;
            moves        <= '0;
            cursor_col   <= CUR_MID;
            wr_en        <= 1'b0;
            col_full_err <= 1'b0;
        end else begin
            wr_en        <= 1'b0;
            col_full_err <= put_full;
            cursor_col   <= cursor_nxt;
            if (put_ok) begin
                wr_en     <= 1'b1;
                wr_row    <= RW'(col_h);
                wr_col    <= cursor_col;
                wr_player <= (state == OPP_TURN);
                player_q  <= (state == OPP_TURN) ? PLAYER_OPP : PLAYER_SELF;
            end
            // The cursor cannot move outside a turn, so wr_col still names the dropped column.
            if (state == DROP) begin
                heights[wr_col] <= heights[wr_col] + HW'(1);
                moves           <= moves + MW'(1);
            end
        end
    end

    tx_pulse_stretch #(
        .TX_HOLD (TX_HOLD)
    ) u_tx_stretch (
        .clk      (clk),
        .rst      (rst),
        .clear    (new_game),
        .ev_in    (tx_ev),
        .tx_lines (tx_lines)
    );

    assign tx_left   = tx_lines[LRP_LEFT];
    assign tx_right  = tx_lines[LRP_RIGHT];
    assign tx_put    = tx_lines[LRP_PUT];
    assign state_dbg = state;

endmodule

// File: tb/tb_turn_controller.sv
// Directed bench for turn_controller: cursor moves, mirroring holds, drops, full-column
// rejection, win/end handling, new_game and a full-board draw.
module tb_turn_controller;
    import connect4_pkg::*;

    logic        clk;
    logic        rst;
    logic [2:0]  lrp_self;
    logic [2:0]  lrp_opponent;
    logic        new_game;
    logic        win_detect;
    logic [2:0]  cursor_col;
    logic        wr_en;
    logic [2:0]  wr_row;
    logic [2:0]  wr_col;
    logic        wr_player;
    logic        self_turn;
    logic        game_end;
    logic        col_full_err;
    logic        tx_left;
    logic        tx_right;
    logic        tx_put;
    turn_state_t state_dbg;

    int n_vec = 0;
    int n_err = 0;
    int exp_cur [9];

    turn_controller #(
        .COLS       (7),
        .ROWS       (6),
        .START_SELF (1),
        .TX_HOLD    (8)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .lrp_self     (lrp_self),
        .lrp_opponent (lrp_opponent),
        .new_game     (new_game),
        .win_detect   (win_detect),
        .cursor_col   (cursor_col),
        .wr_en        (wr_en),
        .wr_row       (wr_row),
        .wr_col       (wr_col),
        .wr_player    (wr_player),
        .self_turn    (self_turn),
        .game_end     (game_end),
        .col_full_err (col_full_err),
        .tx_left      (tx_left),
        .tx_right     (tx_right),
        .tx_put       (tx_put),
        .state_dbg    (state_dbg)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic pulse(input bit opp, input logic [2:0] v);
        if (opp) lrp_opponent = v;
        else     lrp_self     = v;
        @(negedge clk);
        lrp_self     = 3'b000;
        lrp_opponent = 3'b000;
    endtask

    task automatic count_hold(input int sel, output int n);
        logic [2:0] v;
        n = 0;
        for (int i = 0; i < 20; i++) begin
            v = {tx_left, tx_right, tx_put};
            if (!v[sel]) break;
            n++;
            @(negedge clk);
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) @(negedge clk);
    endtask

    // Drop by one player; win_detect is driven during the CHECK cycle.
    task automatic do_put(input bit opp, input int row, input int col, input bit win,
                          input bit exp_self, input bit exp_end);
        pulse(opp, 3'b001);
        check("wr_en", wr_en, 1);
        check("wr_row", wr_row, row);
        check("wr_col", wr_col, col);
        check("wr_player", wr_player, opp);
        @(negedge clk);
        check("wr_en_1cyc", wr_en, 0);
        win_detect = win;
        @(negedge clk);
        win_detect = 1'b0;
        check("self_turn_after", self_turn, exp_self);
        check("game_end_after", game_end, exp_end);
    endtask

    initial begin
        int n;
        int cur;
        int tgt;
        bit who;

`ifdef CURSOR_WRAP_EN
        exp_cur = '{4, 5, 6, 0, 1, 2, 1, 0, 6};
`else
        exp_cur = '{4, 5, 6, 6, 6, 6, 5, 4, 3};
`endif
        rst          = 1'b0;
        lrp_self     = 3'b000;
        lrp_opponent = 3'b000;
        new_game     = 1'b0;
        win_detect   = 1'b0;
        idle(2);

        // Reset state
        check("rst_cursor", cursor_col, 3);
        check("rst_self_turn", self_turn, 1);
        check("rst_tx", {tx_left, tx_right, tx_put}, 0);
        check("rst_wr_en", wr_en, 0);
        check("rst_game_end", game_end, 0);
        check("rst_col_full", col_full_err, 0);
        rst = 1'b1;
        idle(1);

        // Self right x5 with opponent put ignored on the first one
        lrp_opponent = 3'b001;
        pulse(0, 3'b010);
        check("opp_ignored_wr", wr_en, 0);
        check("opp_ignored_turn", self_turn, 1);
        for (int i = 0; i < 5; i++) begin
            if (i != 0) pulse(0, 3'b010);
            check("right_cursor", cursor_col, (i < 3) ? 4 + i : 6);
            check("right_tx_other", {tx_left, tx_put}, 0);
            count_hold(LRP_RIGHT, n);
            check("right_hold", n, 8);
        end

        // Restart rule: a left during a right hold replaces the line
        pulse(0, 3'b010);
        idle(2);
        pulse(0, 3'b100);
        check("restart_cursor", cursor_col, 5);
        check("restart_tx_right", tx_right, 0);
        count_hold(LRP_LEFT, n);
        check("restart_left_hold", n, 8);
        pulse(0, 3'b100);
        pulse(0, 3'b100);
        check("back_to_mid", cursor_col, 3);
        idle(10);

        // Multi-hot left+put resolves to left only
        pulse(0, 3'b101);
        check("multihot_cursor", cursor_col, 2);
        check("multihot_wr", wr_en, 0);
        pulse(0, 3'b010);
        idle(10);

        // Self put at col 3
        pulse(0, 3'b001);
        check("p3_wr_en", wr_en, 1);
        check("p3_row", wr_row, 0);
        check("p3_col", wr_col, 3);
        check("p3_player", wr_player, 0);
        check("p3_tx_put", tx_put, 1);
        check("p3_state_drop", state_dbg, DROP);
        @(negedge clk);
        check("p3_wr_low", wr_en, 0);
        check("p3_state_check", state_dbg, CHECK);
        @(negedge clk);
        check("p3_self_turn", self_turn, 0);
        check("p3_state_opp", state_dbg, OPP_TURN);
        count_hold(LRP_PUT, n);
        check("p3_put_hold_rest", n, 6);

        // Opponent moves to col 0 without mirroring
        for (int i = 0; i < 3; i++) pulse(1, 3'b100);
        check("opp_cursor0", cursor_col, 0);
        check("opp_no_tx", {tx_left, tx_right, tx_put}, 0);

        // Fill col 0 alternately: opponent first here
        for (int k = 0; k < 6; k++)
            do_put((k % 2) == 0, k, 0, 1'b0, (k % 2) == 0, 1'b0);

        pulse(1, 3'b001);
        check("opp_full_err", col_full_err, 1);
        check("opp_full_wr", wr_en, 0);
        check("opp_full_state", state_dbg, OPP_TURN);
        @(negedge clk);
        check("opp_full_err_pulse", col_full_err, 0);

        pulse(1, 3'b010);
        do_put(1, 0, 1, 1'b0, 1'b1, 1'b0);
        pulse(0, 3'b100);
        check("self_cursor0", cursor_col, 0);
        pulse(0, 3'b001);
        check("self_full_err", col_full_err, 1);
        check("self_full_wr", wr_en, 0);
        check("self_full_tx_put", tx_put, 0);
        check("self_full_turn", self_turn, 1);
        @(negedge clk);
        check("self_full_tx_put2", tx_put, 0);

        // Win in CHECK -> END, inputs ignored, then new_game
        pulse(0, 3'b010);
        do_put(0, 1, 1, 1'b1, 1'b0, 1'b1);
        check("win_state", state_dbg, END);
        pulse(0, 3'b100);
        check("end_cursor", cursor_col, 1);
        check("end_tx_left", tx_left, 0);
        pulse(0, 3'b001);
        check("end_self_put", wr_en, 0);
        pulse(1, 3'b001);
        check("end_opp_put", wr_en, 0);
        check("end_still", game_end, 1);
        new_game = 1'b1;
        @(negedge clk);
        new_game = 1'b0;
        check("ng_cursor", cursor_col, 3);
        check("ng_game_end", game_end, 0);
        check("ng_self_turn", self_turn, 1);
        check("ng_tx", {tx_left, tx_right, tx_put}, 0);
        check("ng_wr_en", wr_en, 0);

        // 42 alternating drops, no win -> END after the last
        cur = 3;
        for (int k = 0; k < 42; k++) begin
            who = (k % 2) == 1;
            tgt = k / 6;
            while (cur > tgt) begin pulse(who, 3'b100); cur--; end
            while (cur < tgt) begin pulse(who, 3'b010); cur++; end
            check("draw_cursor", cursor_col, tgt);
            do_put(who, k % 6, tgt, 1'b0, (k == 41) ? 1'b0 : who, k == 41);
        end
        check("draw_state", state_dbg, END);

        // Cursor edges: saturating or wrapping depending on build
        new_game = 1'b1;
        @(negedge clk);
        new_game = 1'b0;
        for (int i = 0; i < 9; i++) begin
            pulse(0, (i < 6) ? 3'b010 : 3'b100);
            check("edge_cursor", cursor_col, exp_cur[i]);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
